axi_tlp_mwr_packer: RTL and testbench

Converts the decoded memory-write chunks produced by the AXI write decoder (address, DW length, BDF, up to 4×256-bit data beats) into a PCIe Memory Write TLP stream. Each chunk becomes one 3DW-header MWr TLP: one header beat followed by 1–4 payload beats on a 256-bit valid/ready stream toward the PCIe transaction-layer TX path. The block sits directly downstream of the AXI write decoder and owns tag allocation and malformed-chunk filtering.

---
 rtl/pcie_tlp_pkg.sv | 27 ++
 rtl/tlp_mwr_hdr_build.sv | 30 +++
 rtl/axi_tlp_mwr_packer.sv | 133 +++++++++++++
 tb/tb_axi_tlp_mwr_packer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// ============================================================================
// pcie_tlp_pkg : shared constants, 3DW header layout and packer FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package pcie_tlp_pkg;

    localparam logic [2:0] FMT_3DW_DATA = 3'b010;
    localparam logic [4:0] TYPE_MEM     = 5'b00000;
    localparam logic [3:0] BE_ALL       = 4'hF;

    typedef struct packed {
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
    } tlp_hdr_3dw_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } tlp_pack_state_t;

endpackage

`default_nettype wire

// File: rtl/tlp_mwr_hdr_build.sv
// ============================================================================
// tlp_mwr_hdr_build : combinational 3DW Memory Write header builder
// Rev 1.0
// ============================================================================
`default_nettype none

module tlp_mwr_hdr_build
    import pcie_tlp_pkg::*;
(
    input  logic [31:0]  addr,
    input  logic [7:0]   length,
    input  logic [15:0]  bdf,
    input  logic [7:0]   tag,
    output tlp_hdr_3dw_t hdr
);

    // A 3DW header carries a DW-aligned address; the byte offset is dropped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    always_comb begin
        hdr.dw0 = {FMT_3DW_DATA, TYPE_MEM, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0,
                   2'b00, 2'b00, 2'b00, length};
        hdr.dw1 = {bdf, tag, BE_ALL, BE_ALL};
        hdr.dw2 = {addr[31:2], 2'b00};
    end

endmodule

`default_nettype wire

// File: rtl/axi_tlp_mwr_packer.sv
// ============================================================================
// axi_tlp_mwr_packer : packs decoded AXI write chunks into PCIe MWr TLP beats
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_tlp_mwr_packer
    import pcie_tlp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 in_addr,
    input  logic [7:0]                            in_length,
    input  logic [15:0]                           in_bdf,
    input  logic                                  in_is_memwrite,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] in_wdata,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [DATA_WIDTH-1:0]                 tlp_data,
    output logic                                  tlp_sop,
    output logic                                  tlp_eop,
    output logic                                  tlp_valid,
    input  logic                                  tlp_ready,
    output logic                                  err_len
);

    localparam int IDX_W = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;
    localparam int CNT_W = $clog2(CHUNK_MAX_BEATS + 1);

    tlp_pack_state_t        r_state;
    logic [31:0]            r_addr;
    logic [7:0]             r_len;
    logic [15:0]            r_bdf;
    logic [7:0]             r_tag;
    logic [CNT_W-1:0]       r_beats;
    logic [IDX_W-1:0]       r_beat_idx;
    logic [DATA_WIDTH-1:0]  r_buf [CHUNK_MAX_BEATS];
    logic                   r_err_len;

    tlp_hdr_3dw_t           w_hdr;
    logic                   w_last;
    logic                   w_drop;
    logic                   w_bad_len;

    tlp_mwr_hdr_build u_hdr_build (
        .addr   (r_addr),
        .length (r_len),
        .bdf    (r_bdf),
        .tag    (r_tag),
        .hdr    (w_hdr)
    );

    // Non-write or empty chunks are silently discarded; malformed lengths flag an error.
    assign w_drop    = !in_is_memwrite || (in_length == 8'd0);
    assign w_bad_len = (in_length[2:0] != 3'b000) || (in_length > 8'(CHUNK_MAX_BEATS * 8));
    assign w_last    = (CNT_W'(r_beat_idx) == (r_beats - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_bdf      <= '0;
            r_tag      <= '0;
            r_beats    <= '0;
            r_beat_idx <= '0;
            r_err_len  <= 1'b0;
            for (int k = 0; k < CHUNK_MAX_BEATS; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_addr  <= in_addr[31:0];
                        r_len   <= in_length;
                        r_bdf   <= in_bdf;
                        r_beats <= CNT_W'(in_length[7:3]);
                        for (int k = 0; k < CHUNK_MAX_BEATS; k++) begin
                            r_buf[k] <= in_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        if (w_drop) begin
                            r_state <= IDLE;
                        end else if (w_bad_len) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (tlp_ready) begin
                        r_state    <= PAY;
                        r_beat_idx <= '0;
                    end
                end
                PAY: begin
                    if (tlp_ready) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_tag   <= r_tag + 8'd1;
                        end else begin
                            r_beat_idx <= r_beat_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = rst_n && (r_state == IDLE);
        tlp_valid = (r_state == HDR) || (r_state == PAY);
        tlp_sop   = (r_state == HDR);
        tlp_eop   = (r_state == PAY) && w_last;
        tlp_data  = '0;
        case (r_state)
            HDR:     tlp_data = {{(DATA_WIDTH-96){1'b0}}, w_hdr.dw2, w_hdr.dw1, w_hdr.dw0};
            PAY:     tlp_data = r_buf[r_beat_idx];
            default: tlp_data = '0;
        endcase
    end

    assign err_len = r_err_len;

endmodule

`default_nettype wire

// File: tb/tb_axi_tlp_mwr_packer.sv
// ============================================================================
// tb_axi_tlp_mwr_packer : randomized bench with a queue-based TLP reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_tlp_mwr_packer;

    localparam int DW = 256;
    localparam int NB = 4;

    typedef struct {
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [15:0]     bdf;
        logic            memw;
        logic [DW*NB-1:0] wdata;
    } chunk_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      in_addr;
    logic [7:0]       in_length;
    logic [15:0]      in_bdf;
    logic             in_is_memwrite;
    logic [DW*NB-1:0] in_wdata;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    tlp_data;
    logic             tlp_sop;
    logic             tlp_eop;
    logic             tlp_valid;
    logic             tlp_ready;
    logic             err_len;

    axi_tlp_mwr_packer #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .CHUNK_MAX_BEATS(NB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_addr        (in_addr),
        .in_length      (in_length),
        .in_bdf         (in_bdf),
        .in_is_memwrite (in_is_memwrite),
        .in_wdata       (in_wdata),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .tlp_data       (tlp_data),
        .tlp_sop        (tlp_sop),
        .tlp_eop        (tlp_eop),
        .tlp_valid      (tlp_valid),
        .tlp_ready      (tlp_ready),
        .err_len        (err_len)
    );

    always #5 clk = ~clk;

    int      n_total = 0;
    int      n_bad   = 0;
    beat_t   exp_q[$];
    logic [7:0] m_tag = 8'd0;
    logic    m_err = 1'b0;
    chunk_t  pend;
    logic    have_pending = 1'b0;
    int      ready_mode = 0;
    int      n_popped = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected TLP built straight from the header field definitions.
    function automatic void model_accept(input chunk_t c);
        beat_t b;
        if (!c.memw || c.len == 8'd0) return;
        if ((c.len % 8) != 0 || c.len > 8'd32) begin
            m_err = 1'b1;
            return;
        end
        b.data = '0;
        b.data[31:0]  = 32'h4000_0000 + 32'(c.len);
        b.data[63:32] = (32'(c.bdf) << 16) | (32'(m_tag) << 8) | 32'h0000_00FF;
        b.data[95:64] = c.addr & 32'hFFFF_FFFC;
        b.sop = 1'b1;
        b.eop = 1'b0;
        exp_q.push_back(b);
        for (int k = 0; k < c.len / 8; k++) begin
            b.data = c.wdata[k*DW +: DW];
            b.sop  = 1'b0;
            b.eop  = (k == c.len / 8 - 1);
            exp_q.push_back(b);
        end
        m_tag = m_tag + 8'd1;
    endfunction

    function automatic chunk_t mk(input logic [31:0] a, input logic [7:0] l,
                                  input logic [15:0] bdf, input logic mw);
        chunk_t c;
        c.addr = a;
        c.len  = l;
        c.bdf  = bdf;
        c.memw = mw;
        for (int i = 0; i < DW*NB/32; i++) c.wdata[i*32 +: 32] = $urandom;
        return c;
    endfunction

    task automatic check_outputs();
        chk("in_ready", {255'b0, in_ready}, {255'b0, exp_q.size() == 0});
        chk("tlp_valid", {255'b0, tlp_valid}, {255'b0, exp_q.size() != 0});
        chk("err_len", {255'b0, err_len}, {255'b0, m_err});
        if (exp_q.size() != 0) begin
            chk("tlp_data", tlp_data, exp_q[0].data);
            chk("tlp_sop", {255'b0, tlp_sop}, {255'b0, exp_q[0].sop});
            chk("tlp_eop", {255'b0, tlp_eop}, {255'b0, exp_q[0].eop});
        end
    endtask

    task automatic step();
        logic in_hs;
        logic out_hs;
        @(negedge clk);
        check_outputs();
        case (ready_mode)
            0:       tlp_ready = 1'b1;
            1:       tlp_ready = !tlp_ready;
            default: tlp_ready = ($urandom_range(0, 3) != 0);
        endcase
        in_valid = have_pending;
        if (have_pending) begin
            in_addr        = pend.addr;
            in_length      = pend.len;
            in_bdf         = pend.bdf;
            in_is_memwrite = pend.memw;
            in_wdata       = pend.wdata;
        end
        in_hs  = in_valid && in_ready;
        out_hs = tlp_valid && tlp_ready;
        @(posedge clk);
        if (out_hs && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_popped++;
        end
        if (in_hs) begin
            model_accept(pend);
            have_pending = 1'b0;
        end
    endtask

    task automatic submit(input chunk_t c);
        int budget;
        budget = 0;
        while (have_pending && budget < 200) begin
            step();
            budget++;
        end
        if (have_pending) chk("submit_timeout", 256'd1, 256'd0);
        pend = c;
        have_pending = 1'b1;
    endtask

    task automatic wait_accept();
        int budget;
        budget = 0;
        while (have_pending && budget < 200) begin
            step();
            budget++;
        end
        if (have_pending) chk("accept_timeout", 256'd1, 256'd0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((have_pending || exp_q.size() != 0) && budget < 2000) begin
            step();
            budget++;
        end
        if (have_pending || exp_q.size() != 0) chk("drain_timeout", 256'd1, 256'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        have_pending = 1'b0;
        exp_q.delete();
        m_tag = 8'd0;
        m_err = 1'b0;
        #1;
        chk("rst_in_ready", {255'b0, in_ready}, 256'd0);
        chk("rst_tlp_valid", {255'b0, tlp_valid}, 256'd0);
        chk("rst_tlp_sop", {255'b0, tlp_sop}, 256'd0);
        chk("rst_tlp_eop", {255'b0, tlp_eop}, 256'd0);
        chk("rst_tlp_data", tlp_data, 256'd0);
        chk("rst_err_len", {255'b0, err_len}, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_addr = '0;
        in_length = '0;
        in_bdf = '0;
        in_is_memwrite = 1'b0;
        in_wdata = '0;
        in_valid = 1'b0;
        tlp_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reference chunk with known header words.
        ready_mode = 0;
        submit(mk(32'h1000_0040, 8'd8, 16'h0200, 1'b1));
        wait_accept();
        #1 chk("ex_hdr", {160'b0, tlp_data[95:0]},
               {160'b0, 96'h1000_0040_0200_00FF_4000_0008});
        drain();

        // 32 DW chunk with stalls every other cycle.
        ready_mode = 1;
        submit(mk(32'h2345_6788, 8'd32, 16'h1234, 1'b1));
        wait_accept();
        #1 chk("dw0_32", {224'b0, tlp_data[31:0]}, {224'b0, 32'h4000_0020});
        drain();

        // Back-to-back chunks across the tag wrap.
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 257; i++) begin
            submit(mk($urandom, 8'd8, 16'(i), 1'b1));
            wait_accept();
        end
        drain();

        // Dropped chunks: illegal length, zero length, non-write.
        submit(mk(32'h0000_1000, 8'd12, 16'h0001, 1'b1));
        drain();
        submit(mk(32'h0000_2000, 8'd0, 16'h0002, 1'b1));
        drain();
        submit(mk(32'h0000_3000, 8'd16, 16'h0003, 1'b0));
        drain();
        submit(mk(32'h0000_4000, 8'd8, 16'h0004, 1'b1));
        drain();

        // Random traffic mixing legal and illegal lengths with random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 80; i++) begin
            logic [7:0] l;
            case ($urandom_range(0, 9))
                0:       l = 8'd0;
                1:       l = 8'($urandom_range(1, 255));
                2:       l = 8'd40;
                default: l = 8'(8 * $urandom_range(1, 4));
            endcase
            submit(mk($urandom, l, 16'($urandom), ($urandom_range(0, 7) != 0)));
            repeat ($urandom_range(0, 2)) step();
        end
        drain();

        // Reset while the third payload beat of a 32 DW TLP is on the bus.
        do_reset();
        ready_mode = 0;
        submit(mk(32'hABCD_0000, 8'd32, 16'h0777, 1'b1));
        n_popped = 0;
        for (int b = 0; b < 40 && n_popped < 3; b++) step();
        chk("mid_pop", 256'(n_popped), 256'd3);
        @(negedge clk);
        chk("mid_valid_pre", {255'b0, tlp_valid}, 256'd1);
        rst_n = 1'b0;
        exp_q.delete();
        m_tag = 8'd0;
        m_err = 1'b0;
        #1;
        chk("mid_rst_valid", {255'b0, tlp_valid}, 256'd0);
        chk("mid_rst_data", tlp_data, 256'd0);
        chk("mid_rst_eop", {255'b0, tlp_eop}, 256'd0);
        chk("mid_rst_ready", {255'b0, in_ready}, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        submit(mk(32'h5000_0000, 8'd8, 16'h0300, 1'b1));
        wait_accept();
        #1 chk("post_rst_dw1", {224'b0, tlp_data[63:32]}, {224'b0, 32'h0300_00FF});
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
